// File: rtl/memory_stage.sv
// Execute-to-writeback stage: latches results, performs LDW/STW on block RAM and the board I/O window.
// One-cycle latency for all outputs; no back-pressure, one instruction accepted every cycle.
module memory_stage #(
  parameter int REG_WIDTH       = 16,
  parameter int OPCODE_WIDTH    = 8,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter logic [REG_WIDTH-1:0]    IO_BASE = 16'hFF00,
  parameter logic [OPCODE_WIDTH-1:0] OP_LDW  = 8'h60,
  parameter logic [OPCODE_WIDTH-1:0] OP_STW  = 8'h70
) (
  input  logic                    I_CLOCK,
  input  logic                    I_LOCK,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [REG_WIDTH-1:0]    I_StoreData,
  input  logic [3:0]              I_DestRegIdx,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [REG_WIDTH-1:0]    O_ALUOut,
  output logic [REG_WIDTH-1:0]    O_MemOut,
  output logic [3:0]              O_DestRegIdx,
  output logic                    O_FetchStall,
  output logic                    O_DepStall,
  output logic [9:0]              O_LEDR,
  output logic [7:0]              O_LEDG,
  output logic [15:0]             O_HEX
);

  localparam int DEPTH = 1 << DMEM_ADDR_WIDTH;

  logic [REG_WIDTH-1:0] mem [DEPTH];

  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [REG_WIDTH-1:0]    aluout_q;
  logic [3:0]              dest_q;
  logic                    fstall_q;
  logic                    dstall_q;
  logic [9:0]              ledr_q, ledr_d;
  logic [7:0]              ledg_q, ledg_d;
  logic [15:0]             hex_q, hex_d;
  logic                    ld_mem_q, ld_mem_d;
  logic [REG_WIDTH-1:0]    io_rdata_q, io_rdata_d;
  logic [REG_WIDTH-1:0]    mem_rdata_q;

  logic                       valid, is_ld, is_st, is_io, mem_we;
  logic                       sel_ledr, sel_ledg, sel_hex;
  logic [DMEM_ADDR_WIDTH-1:0] word_idx;

  assign valid    = ~I_FetchStall & ~I_DepStall;
  assign is_ld    = valid && (I_Opcode == OP_LDW);
  assign is_st    = valid && (I_Opcode == OP_STW);
  assign is_io    = (I_ALUOut >= IO_BASE);
  assign word_idx = I_ALUOut[DMEM_ADDR_WIDTH:1];
  assign sel_ledr = (I_ALUOut == IO_BASE);
  assign sel_ledg = (I_ALUOut == IO_BASE + REG_WIDTH'(2));
  assign sel_hex  = (I_ALUOut == IO_BASE + REG_WIDTH'(4));
  // Reset suppresses the write of the instruction being captured on that edge.
  assign mem_we   = I_LOCK & is_st & ~is_io;

  always_comb begin
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    hex_d      = hex_q;
    ld_mem_d   = 1'b0;
    io_rdata_d = '0;
    if (is_st && is_io) begin
      if (sel_ledr) ledr_d = I_StoreData[9:0];
      if (sel_ledg) ledg_d = I_StoreData[7:0];
      if (sel_hex)  hex_d  = I_StoreData[15:0];
    end
    if (is_ld) begin
      if (!is_io) begin
        ld_mem_d = 1'b1;
      end else if (sel_ledr) begin
        io_rdata_d = REG_WIDTH'(ledr_q);
      end else if (sel_ledg) begin
        io_rdata_d = REG_WIDTH'(ledg_q);
      end else if (sel_hex) begin
        io_rdata_d = REG_WIDTH'(hex_q);
      end
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (!I_LOCK) begin
      opcode_q   <= '0;
      aluout_q   <= '0;
      dest_q     <= '0;
      fstall_q   <= 1'b0;
      dstall_q   <= 1'b0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_q      <= '0;
      ld_mem_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      opcode_q   <= I_Opcode;
      aluout_q   <= I_ALUOut;
      dest_q     <= I_DestRegIdx;
      fstall_q   <= I_FetchStall;
      dstall_q   <= I_DepStall;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hex_q      <= hex_d;
      ld_mem_q   <= ld_mem_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  // Plain RAM process without reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge I_CLOCK) begin
    if (mem_we) mem[word_idx] <= I_StoreData;
    mem_rdata_q <= mem[word_idx];
  end

  assign O_Opcode     = opcode_q;
  assign O_ALUOut     = aluout_q;
  assign O_MemOut     = ld_mem_q ? mem_rdata_q : io_rdata_q;
  assign O_DestRegIdx = dest_q;
  assign O_FetchStall = fstall_q;
  assign O_DepStall   = dstall_q;
  assign O_LEDR       = ledr_q;
  assign O_LEDG       = ledg_q;
  assign O_HEX        = hex_q;

endmodule
